// File: rtl/regfile_seq_pkg.sv
// rtl/regfile_seq_pkg.sv - shared op encodings, FSM states and default widths for the register-file sequencer
package regfile_seq_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int RA_W_DEF   = 2;
  localparam int WA_W_DEF   = 3;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    OP_LDI = 2'b00,
    OP_MOV = 2'b01,
    OP_ADD = 2'b10,
    OP_RD  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    EXEC  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/regfile_sequencer_if.sv
// rtl/regfile_sequencer_if.sv - command, register-file and result signals of the sequencer
interface regfile_sequencer_if
  import regfile_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RA_W   = RA_W_DEF,
  parameter int WA_W   = WA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [RA_W-1:0]   cmd_dst;
  logic [RA_W-1:0]   cmd_srca;
  logic [RA_W-1:0]   cmd_srcb;
  logic [DATA_W-1:0] cmd_imm;

  logic [RA_W-1:0]   rp;
  logic [RA_W-1:0]   rq;
  logic [DATA_W-1:0] datap;
  logic [DATA_W-1:0] dataq;
  logic [WA_W-1:0]   wa;
  logic              wr;
  logic [DATA_W-1:0] ld_data;

  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_carry;
  logic [CNT_W-1:0]  ops_done;

  // master is the sequencer itself; slave is the front end plus register file
  modport master (
    input  cmd_valid, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_imm, datap, dataq,
    output cmd_ready, rp, rq, wa, wr, ld_data, res_valid, res_data, res_carry, ops_done
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_imm, datap, dataq,
    input  cmd_ready, rp, rq, wa, wr, ld_data, res_valid, res_data, res_carry, ops_done
  );

endinterface

// File: rtl/regfile_seq_alu.sv
// rtl/regfile_seq_alu.sv - combinational result/carry computation for one sequencer op
module regfile_seq_alu
  import regfile_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  op_t               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    result = a;
    carry  = 1'b0;
    case (op)
      OP_LDI:  result = imm;
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      default: result = a;
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - one-op-at-a-time initiator sequencing reads, compute and write-back on a 4x4 register file
module regfile_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RA_W   = RA_W_DEF,
  parameter int WA_W   = WA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input logic                 clk,
  input logic                 rst,
  regfile_sequencer_if.master bus
);

  state_t            state;
  op_t               op_q;
  logic [RA_W-1:0]   dst_q;
  logic [RA_W-1:0]   srca_q;
  logic [RA_W-1:0]   srcb_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] result_q;
  logic              carry_q;
  logic [DATA_W-1:0] res_data_q;
  logic              res_carry_q;
  logic [CNT_W-1:0]  ops_q;

  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;

  regfile_seq_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .imm    (imm_q),
    .result (alu_res),
    .carry  (alu_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op_q        <= OP_LDI;
      dst_q       <= '0;
      srca_q      <= '0;
      srcb_q      <= '0;
      imm_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      ops_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_q   <= op_t'(bus.cmd_op);
            dst_q  <= bus.cmd_dst;
            srca_q <= bus.cmd_srca;
            srcb_q <= bus.cmd_srcb;
            imm_q  <= bus.cmd_imm;
            state  <= (op_t'(bus.cmd_op) == OP_LDI) ? EXEC : READ;
          end
        end
        READ: begin
          a_q   <= bus.datap;
          b_q   <= bus.dataq;
          state <= EXEC;
        end
        EXEC: begin
          result_q <= alu_res;
          carry_q  <= alu_carry;
          // RD skips write-back, so its result must be published on this edge to land in DONE
          if (op_q == OP_RD) begin
            res_data_q  <= alu_res;
            res_carry_q <= alu_carry;
            state       <= DONE;
          end else begin
            state <= WRITE;
          end
        end
        WRITE: begin
          res_data_q  <= result_q;
          res_carry_q <= carry_q;
          state       <= DONE;
        end
        DONE: begin
          ops_q <= ops_q + CNT_W'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.rp        = srca_q;
  assign bus.rq        = srcb_q;
  assign bus.wa        = {{(WA_W-RA_W){1'b0}}, dst_q};
  assign bus.wr        = (state == WRITE);
  assign bus.ld_data   = result_q;
  assign bus.res_valid = (state == DONE);
  assign bus.res_data  = res_data_q;
  assign bus.res_carry = res_carry_q;
  assign bus.ops_done  = ops_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb/tb_regfile_sequencer.sv - directed self-checking bench with a behavioural 4x4 register file
module tb_regfile_sequencer;

  logic clk;
  logic rst;
  logic rf_clr;
  logic [3:0] rf [4];

  int n_cmp = 0;
  int n_err = 0;

  regfile_sequencer_if bus ();

  regfile_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 4; i++) rf[i] <= 4'h0;
    end else if (bus.wr) begin
      rf[bus.wa[1:0]] <= bus.ld_data;
    end
  end

  assign bus.datap = rf[bus.rp];
  assign bus.dataq = rf[bus.rq];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [1:0] dst, input logic [1:0] srca,
                        input logic [1:0] srcb, input logic [3:0] imm,
                        output int lat, output int wr_cnt, output logic [2:0] wa_s,
                        output logic [3:0] ld_s);
    int guard;
    lat = 0; wr_cnt = 0; wa_s = 3'h0; ld_s = 4'h0;
    bus.cmd_op = op; bus.cmd_dst = dst; bus.cmd_srca = srca;
    bus.cmd_srcb = srcb; bus.cmd_imm = imm; bus.cmd_valid = 1'b1;
    guard = 0;
    while (!bus.cmd_ready && guard < 20) begin
      tick();
      guard++;
    end
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_imm = ~imm;
    for (int c = 1; c <= 10; c++) begin
      if (bus.wr) begin
        wr_cnt++;
        wa_s = bus.wa;
        ld_s = bus.ld_data;
      end
      if (bus.res_valid) begin
        lat = c;
        break;
      end
      tick();
    end
    tick();
  endtask

  int lat, wc, acc, busy, g, rv;
  logic [2:0] was;
  logic [3:0] lds;

  initial begin
    rst = 1'b1; rf_clr = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_dst = 2'b00;
    bus.cmd_srca = 2'b00; bus.cmd_srcb = 2'b00; bus.cmd_imm = 4'h0;
    tick(); tick();
    rst = 1'b0; rf_clr = 1'b0;
    check("rst_ready", bus.cmd_ready, 1);
    check("rst_wr", bus.wr, 0);
    check("rst_ops", bus.ops_done, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_res_valid", bus.res_valid, 0);

    rv = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.res_valid || bus.wr) rv++;
    end
    check("idle_hold_ready", bus.cmd_ready, 1);
    check("idle_hold_quiet", rv, 0);

    // LDI R2 <= 0xA
    run_op(2'b00, 2'd2, 2'd0, 2'd0, 4'hA, lat, wc, was, lds);
    check("ldi_lat", lat, 3);
    check("ldi_wr_cnt", wc, 1);
    check("ldi_wa", was, 3'b010);
    check("ldi_ld_data", lds, 4'hA);
    check("ldi_res", bus.res_data, 4'hA);
    check("ldi_rf", rf[2], 4'hA);

    run_op(2'b11, 2'd0, 2'd2, 2'd0, 4'h0, lat, wc, was, lds);
    check("rd_lat", lat, 3);
    check("rd_wr_cnt", wc, 0);
    check("rd_res", bus.res_data, 4'hA);

    // ADD overflow
    run_op(2'b00, 2'd0, 2'd0, 2'd0, 4'hF, lat, wc, was, lds);
    run_op(2'b00, 2'd1, 2'd0, 2'd0, 4'h1, lat, wc, was, lds);
    run_op(2'b10, 2'd3, 2'd0, 2'd1, 4'h0, lat, wc, was, lds);
    check("add_lat", lat, 4);
    check("add_res", bus.res_data, 4'h0);
    check("add_carry", bus.res_carry, 1);
    check("add_rf", rf[3], 4'h0);

    // aliasing: destination equals both sources
    run_op(2'b00, 2'd1, 2'd0, 2'd0, 4'h5, lat, wc, was, lds);
    check("ldi_carry_clr", bus.res_carry, 0);
    run_op(2'b10, 2'd1, 2'd1, 2'd1, 4'h0, lat, wc, was, lds);
    check("alias_add_res", bus.res_data, 4'hA);
    check("alias_add_carry", bus.res_carry, 0);
    check("alias_add_rf", rf[1], 4'hA);
    run_op(2'b01, 2'd0, 2'd1, 2'd0, 4'h0, lat, wc, was, lds);
    check("mov_lat", lat, 4);
    check("mov_res", bus.res_data, 4'hA);
    check("mov_rf", rf[0], 4'hA);
    check("ops_after_8", bus.ops_done, 8);

    // CMD_VALID held high for 10 cycles with changing fields
    acc = 0; busy = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 2'b00;
    for (int k = 0; k < 10; k++) begin
      bus.cmd_dst = 2'(k % 3);
      bus.cmd_imm = 4'(k);
      bus.cmd_srca = 2'(k);
      bus.cmd_srcb = 2'(k + 1);
      if (bus.cmd_ready) acc++;
      else busy++;
      tick();
    end
    bus.cmd_valid = 1'b0;
    g = 0;
    while (!bus.cmd_ready && g < 20) begin
      tick();
      g++;
    end
    check("hs_accepts", acc, 3);
    check("hs_busy_cycles", busy, 7);
    check("hs_rf0", rf[0], 4'h0);
    check("hs_rf1", rf[1], 4'h4);
    check("hs_rf2", rf[2], 4'h8);
    check("hs_ops", bus.ops_done, 11);

    // reset asserted during WRITE of LDI R3 <= 7
    bus.cmd_op = 2'b00; bus.cmd_dst = 2'd3; bus.cmd_imm = 4'h7; bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    check("mw_wr_hi", bus.wr, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mw_wr_lo", bus.wr, 0);
    check("mw_ready", bus.cmd_ready, 1);
    check("mw_ops", bus.ops_done, 0);
    rv = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.res_valid) rv++;
      tick();
    end
    check("mw_no_res", rv, 0);
    check("mw_res_data", bus.res_data, 0);

    // counter wrap
    for (int i = 0; i < 255; i++) run_op(2'b11, 2'd0, 2'd1, 2'd0, 4'h0, lat, wc, was, lds);
    check("ops_255", bus.ops_done, 255);
    run_op(2'b11, 2'd0, 2'd1, 2'd0, 4'h0, lat, wc, was, lds);
    check("ops_wrap", bus.ops_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
